// File: rtl/sram_loader.sv
// UART boot loader: receives a little-endian length header followed by image bytes and writes
// them to SRAM, then releases the core reset. Optional trailing XOR checksum: SRAM_LOADER_CHECKSUM_EN.
module sram_loader #(
  parameter int AW           = 14,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rx_i,
  output logic [AW-1:0] sram_waddr_o,
  output logic [7:0]    sram_wdata_o,
  output logic          sram_wen_o,
  output logic          core_rst_no,
  output logic          done_o,
  output logic          err_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [16:0]   MAX_LEN = 17'(1) << AW;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef SRAM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_e;

`ifdef SRAM_LOADER_CHECKSUM_EN
  localparam state_e POST_DATA = S_CHK;
`else
  localparam state_e POST_DATA = S_DONE;
`endif

  // rx_prev_q is one more stage on the synchronized line, used only for edge detection
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic byte_vld, frame_err;

  state_e state_q, state_d;
  logic [15:0] len_q, len_d, idx_q, idx_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic wen_q, wen_d, done_q, done_d, err_q, err_d;
`ifdef SRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_vld   = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          // A start bit that has gone high again by mid-bit was a glitch
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
          else               bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          byte_vld   = rx_sync_q;
          frame_err  = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_LEN_LO;
      len_q   <= '0;
      idx_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SRAM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SRAM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    done_d  = (state_q == S_DONE);
    err_d   = (state_q == S_ERR);
`ifdef SRAM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (state_q != S_DONE && state_q != S_ERR) begin
      if (frame_err) begin
        state_d = S_ERR;
      end else if (byte_vld) begin
        case (state_q)
          S_LEN_LO: begin
            len_d   = {8'h00, shift_q};
            state_d = S_LEN_HI;
          end
          S_LEN_HI: begin
            len_d = {shift_q, len_q[7:0]};
            if ({1'b0, shift_q, len_q[7:0]} > MAX_LEN)  state_d = S_ERR;
            else if ({shift_q, len_q[7:0]} == 16'd0)    state_d = POST_DATA;
            else                                        state_d = S_DATA;
          end
          S_DATA: begin
            wen_d   = 1'b1;
            waddr_d = idx_q[AW-1:0];
            wdata_d = shift_q;
            idx_d   = idx_q + 16'd1;
`ifdef SRAM_LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ shift_q;
`endif
            if (idx_q == len_q - 16'd1) state_d = POST_DATA;
          end
`ifdef SRAM_LOADER_CHECKSUM_EN
          S_CHK: state_d = (shift_q == csum_q) ? S_DONE : S_ERR;
`endif
          default: ;
        endcase
      end
    end
  end

  assign sram_waddr_o = waddr_q;
  assign sram_wdata_o = wdata_q;
  assign sram_wen_o   = wen_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign core_rst_no  = done_q;

endmodule

// File: tb/tb_sram_loader.sv
// Directed bench for sram_loader (CLKS_PER_BIT=4, AW=14); honours SRAM_LOADER_CHECKSUM_EN.
module tb_sram_loader;
  localparam int AW  = 14;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic [AW-1:0] sram_waddr;
  logic [7:0] sram_wdata;
  logic sram_wen, core_rst_n, done, err;

  int n_checks = 0;
  int n_bad = 0;
  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] obs_q[$];

  sram_loader #(.AW(AW), .CLKS_PER_BIT(CPB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx),
    .sram_waddr_o(sram_waddr), .sram_wdata_o(sram_wdata), .sram_wen_o(sram_wen),
    .core_rst_no(core_rst_n), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sram_wen) obs_q.push_back({sram_waddr, sram_wdata});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wen"}, 32'(sram_wen), 32'd0);
    check({tag, "_waddr"}, 32'(sram_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  // Waits for a terminal flag, then checks flags and the collected writes
  task automatic finish_image(input string tag, input logic exp_done);
    int n = 0;
    while (!(done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_err"}, 32'(err), 32'(!exp_done));
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(exp_done));
    check({tag, "_n_writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_write"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    do_reset();

    // three-byte image
    send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'h0F, 1'b1);
`ifdef SRAM_LOADER_CHECKSUM_EN
    send_byte(8'hF0, 1'b1);
`endif
    exp_q.push_back({14'd0, 8'hAA});
    exp_q.push_back({14'd1, 8'h55});
    exp_q.push_back({14'd2, 8'h0F});
    finish_image("img3", 1'b1);
    // terminal state ignores further traffic
    send_byte(8'h01, 1'b1);
    repeat (8) @(negedge clk);
    check("done_sticky_writes", 32'(obs_q.size()), 32'd0);
    check("done_sticky", 32'(done), 32'd1);

    // two-byte image; bad checksum when enabled, clean load otherwise
    do_reset();
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    exp_q.push_back({14'd0, 8'h11});
    exp_q.push_back({14'd1, 8'h22});
`ifdef SRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
    finish_image("badsum", 1'b0);
`else
    finish_image("img2", 1'b1);
`endif

    // oversize length 0x4101
    do_reset();
    send_byte(8'h01, 1'b1); send_byte(8'h41, 1'b1);
    finish_image("oversize", 1'b0);

    // exact maximum length 0x4000 is accepted: no error after the header
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h40, 1'b1);
    repeat (20) @(negedge clk);
    check("maxlen_err", 32'(err), 32'd0);
    check("maxlen_done", 32'(done), 32'd0);

    // framing error on second data byte
    do_reset();
    send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b0); send_byte(8'h0F, 1'b1);
    exp_q.push_back({14'd0, 8'hAA});
    finish_image("frame", 1'b0);

    // framing error on the length header
    do_reset();
    send_byte(8'h03, 1'b0);
    finish_image("frame_hdr", 1'b0);

    // one-cycle glitch while idle, then an empty image
    do_reset();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (6 * CPB) @(negedge clk);
    check("glitch_err", 32'(err), 32'd0);
    check("glitch_writes", 32'(obs_q.size()), 32'd0);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
`ifdef SRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    finish_image("empty", 1'b1);

    // reset mid-DATA, then a fresh one-byte image
    do_reset();
    send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hAA, 1'b1);
    check("mid_pre_writes", 32'(obs_q.size()), 32'd1);
    rx = 1'b0;
    repeat (CPB + 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    do_reset();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h7E, 1'b1);
`ifdef SRAM_LOADER_CHECKSUM_EN
    send_byte(8'h7E, 1'b1);
`endif
    exp_q.push_back({14'd0, 8'h7E});
    finish_image("after_rst", 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_loader.md
SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 SHALL have parameter AW, default 14, the SRAM byte-address width (memory size 2^AW bytes).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, the clk_i cycles per UART bit (minimum 4).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx_i, input, 1, UART receive line, idle high, asynchronous to clk_i.
REQ-006 SHALL have port sram_waddr_o, output, AW, SRAM write byte address.
REQ-007 SHALL have port sram_wdata_o, output, 8, SRAM write data.
REQ-008 SHALL have port sram_wen_o, output, 1, single-cycle SRAM write strobe.
REQ-009 SHALL have port core_rst_no, output, 1, active-low reset to the SoC core; low until load completes.
REQ-010 SHALL have port done_o, output, 1, image loaded successfully (sticky).
REQ-011 SHALL have port err_o, output, 1, load failed (sticky).

Function
REQ-012 SHALL pass rx_i through a two-flop synchronizer before any use.
REQ-013 SHALL detect a start bit on a synchronized high-to-low transition while the receiver is idle.
REQ-014 SHALL sample each bit at CLKS_PER_BIT/2 cycles into the bit period: start, 8 data LSB-first, 1 stop.
REQ-015 SHALL abort if the start-bit re-sample is high (glitch): return to idle, no byte, no error.
REQ-016 SHALL flag a framing error if the stop bit samples low.
REQ-017 SHALL use FSM states LEN_LO, LEN_HI, DATA, CHK, DONE, ERR; reset state LEN_LO.
REQ-018 SHALL store the first received byte as length[7:0] and the second as length[15:8], little-endian.
REQ-019 SHALL enter ERR after LEN_HI if length > 2^AW.
REQ-020 SHALL, in DATA, pulse sram_wen_o for exactly one cycle per received byte, one cycle after the stop-bit sample.
REQ-021 SHALL drive sram_waddr_o = byte index (0, 1, 2, ...) and sram_wdata_o = byte during the strobe.
REQ-022 SHALL hold sram_waddr_o and sram_wdata_o at their last values when not strobing.
REQ-023 SHALL leave DATA after byte index length-1; length 0 skips DATA entirely.
REQ-024 SHALL enter ERR from any non-terminal state on a framing error.
REQ-025 SHALL treat DONE and ERR as terminal and ignore rx_i there until reset.
REQ-026 SHALL set done_o=1 and core_rst_no=1 in the cycle after entering DONE.
REQ-027 SHALL set err_o=1 in ERR, with core_rst_no held 0.
REQ-028 SHALL never assert done_o and err_o together.

Reset
REQ-029 SHALL, while rst_ni=0, set sram_wen_o=0, sram_waddr_o=0, sram_wdata_o=0, core_rst_no=0, done_o=0 and err_o=0.
REQ-030 SHALL, on reset, set the FSM to LEN_LO, the receiver to idle, and clear all counters and the checksum.
REQ-031 SHALL, on reset asserted mid-byte or mid-image, discard the partial load; the host restarts from the length header.

Configuration
REQ-032 SHALL implement checksum checking only when SRAM_LOADER_CHECKSUM_EN is defined.
REQ-033 SHALL, with SRAM_LOADER_CHECKSUM_EN defined, XOR-accumulate all data bytes; after DATA (or LEN_HI if length 0), CHK receives one byte; match -> DONE, mismatch -> ERR.
REQ-034 SHALL, without SRAM_LOADER_CHECKSUM_EN, have no CHK state and go to DONE directly after the last data byte (or after LEN_HI if length 0).

Verification (CLKS_PER_BIT=4, AW=14)
REQ-035 SHALL cover: bytes 03 00 AA 55 0F [+ checksum F0] -> writes (0,AA),(1,55),(2,0F), then done_o=1, core_rst_no=1.
REQ-036 SHALL cover: with CHECKSUM_EN, bytes 02 00 11 22 then checksum 00 -> err_o=1, core_rst_no=0, two writes observed.
REQ-037 SHALL cover: bytes 01 41 (length 0x4101 > 0x4000) -> err_o=1, no sram_wen_o pulse.
REQ-038 SHALL cover: stop bit driven low on the 2nd data byte -> err_o=1 and exactly one write.
REQ-039 SHALL cover: rx_i low for 1 cycle while idle -> no byte, no error; then a valid 00 00 [+00] image -> done_o=1.
REQ-040 SHALL cover: rst_ni pulsed low mid-DATA -> all outputs at reset values, then a fresh 01 00 7E [+7E] image -> write (0,7E) and done_o=1.
